wb_fuzz_burst_master: RTL and testbench
=======================================

Name: wb_fuzz_burst_master

Overview:
- Parametrised Wishbone B4 incrementing-burst master that replaces the fixed-length master half of the fuzzer's dual bridge.
- The central fuzzer issues one request through a valid/ready channel.
  - Runtime beat count 1..MAX_BEATS.
  - Per-request byte select.
- Bus errors and slave timeouts abort the burst and are reported back, so the fuzzer no longer hangs on an unresponsive slave.
- Sits between the central fuzzer and the DUT's Wishbone interconnect.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; multiple of 8.
- MAX_BEATS, 8, maximum beats per burst; power of two, ≥ 2.
- TIMEOUT_CYCLES, 256, cycles without ack/err before abort; ≥ 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fuzzer request valid.
- req_ready  out  1  master can accept a request.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  start byte address.
- req_len  in  $clog2(MAX_BEATS)  beats minus one.
- req_sel  in  DATA_WIDTH/8  byte select, applied to all beats.
- req_wdata  in  MAX_BEATS*DATA_WIDTH  write data; beat i in slice [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  fuzzer consumes response.
- rsp_rdata  out  MAX_BEATS*DATA_WIDTH  read data, same packing as req_wdata.
- rsp_status  out  2  00 OK, 01 ERR, 10 TIMEOUT.
- rsp_beats  out  $clog2(MAX_BEATS)+1  beats acknowledged.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone controls.
- wbm_adr_o  out  ADDR_WIDTH  address.
- wbm_dat_o  out  DATA_WIDTH  write data.
- wbm_dat_i  in  DATA_WIDTH  read data.
- wbm_sel_o  out  DATA_WIDTH/8  byte select.
- wbm_cti_o  out  3  cycle type.
- wbm_bte_o  out  2  burst type; always 00 (linear).
- wbm_ack_i, wbm_err_i  in  1 each  slave termination.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0, except req_ready = 1 and wbm_sel_o = all ones.
  - State IDLE.
  - Buffers and counters cleared.
  - A burst in flight is dropped: cyc/stb fall immediately, no response issued.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch we, addr, len, sel, wdata; clear the read buffer to zero; go to BUS.
  - In the next cycle cyc/stb = 1, adr = req_addr, dat_o = beat 0.
- BUS:
  - cyc/stb held high continuously; adr/dat_o/sel/we stable until termination.
  - cti = 010 on every beat except the last, which is 111.
  - len = 0 → cti = 000 (classic single access).
  - Beat terminated by ack:
    - Read: dat_i stored in buffer[beat].
    - beat++; adr += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH; dat_o advances to the next beat.
    - Ack on the last beat: cyc/stb deasserted on that same edge; status OK; go to RESP.
  - err_i asserted:
    - cyc/stb dropped; status ERR; rsp_beats = beats acked so far; go to RESP.
    - ack and err in the same cycle: err wins, that beat is not counted.
  - Timeout:
    - Counter clears at BUS entry and on every ack.
    - When it reaches TIMEOUT_CYCLES−1 with no termination: abort, status TIMEOUT, go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1 with stable rdata/status/beats until rsp_ready.
  - Handshake cycle: go to IDLE, rsp_valid drops.
  - Earliest next request is accepted on the following cycle.
- Latency, full read burst of N beats with zero-wait acks: rsp_valid rises N+1 cycles after request acceptance.
- Write bursts return rsp_rdata = 0.

Optional Feature:
- Macro: WB_FUZZ_STATS_EN.
- Defined:
  - Adds outputs stat_txn_cnt[31:0], stat_err_cnt[15:0], stat_to_cnt[15:0].
  - Counts completed responses, ERR and TIMEOUT respectively.
  - Counters saturate, clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_fuzz_pkg holds:
  - Cycle-type constants: CTI_CLASSIC = 000, CTI_INCR = 010, CTI_END = 111.
  - BTE_LINEAR.
  - Status enum: ST_OK, ST_ERR, ST_TIMEOUT.
  - State typedef: IDLE, BUS, RESP.
- One sub-module: wb_fuzz_timeout, a parametrised saturating counter with clear and expiry-pulse output.

Test Plan:
- Read, len = 7, addr 0x1000, zero-wait slave returning 0xA0+i → adr steps 0x1000..0x101C; cti 010×7 then 111; rsp_rdata beat i = 0xA0+i; status OK; beats 8; rsp_valid 9 cycles after accept.
- Write, len = 0, addr 0x20, sel 4'b0011, wdata 0xDEADBEEF → one access, cti 000, sel 0011, dat_o 0xDEADBEEF; status OK; beats 1.
- Read, len = 3, err_i on beat 2 → cyc drops same cycle; status ERR; beats 2; rdata beats 2–3 are zero.
- Slave never acks, TIMEOUT_CYCLES = 16 → cyc high exactly 16 cycles, then status TIMEOUT, beats 0.
- Write, len = 1, addr 0xFFFF_FFFC → second beat adr 0x0000_0000; rsp_ready held low 5 cycles keeps rsp_valid and its data stable.
- rst_n low mid-burst at beat 3 → cyc/stb 0 asynchronously; no response; next request runs normally.

Source files
------------

// File: rtl/wb_fuzz_pkg.sv
// Shared constants and types for the Wishbone fuzz burst master.
package wb_fuzz_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/wb_fuzz_timeout.sv
// Saturating cycle counter with synchronous clear. expired pulses in the
// cycle the count sits at CYCLES-1 while enabled and not being cleared.
module wb_fuzz_timeout #(
  parameter int unsigned CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // count up while enabled, hold at LAST, clear on request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + CW'(1);
  end

  assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/wb_fuzz_burst_master.sv
// Wishbone B4 incrementing-burst master driven by a single valid/ready
// request channel. Bursts end on final ack, on err_i, or on slave timeout;
// the outcome is returned on the response channel.
// Optional statistics counters are built when WB_FUZZ_STATS_EN is defined.
module wb_fuzz_burst_master
  import wb_fuzz_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_BEATS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [$clog2(MAX_BEATS)-1:0]     req_len,
  input  logic [DATA_WIDTH/8-1:0]          req_sel,
  input  logic [MAX_BEATS*DATA_WIDTH-1:0]  req_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [MAX_BEATS*DATA_WIDTH-1:0]  rsp_rdata,
  output logic [1:0]                       rsp_status,
  output logic [$clog2(MAX_BEATS):0]       rsp_beats,
  output logic                             wbm_cyc_o,
  output logic                             wbm_stb_o,
  output logic                             wbm_we_o,
  output logic [ADDR_WIDTH-1:0]            wbm_adr_o,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH/8-1:0]          wbm_sel_o,
  output logic [2:0]                       wbm_cti_o,
  output logic [1:0]                       wbm_bte_o,
  input  logic                             wbm_ack_i,
  input  logic                             wbm_err_i
`ifdef WB_FUZZ_STATS_EN
  ,
  output logic [31:0]                      stat_txn_cnt,
  output logic [15:0]                      stat_err_cnt,
  output logic [15:0]                      stat_to_cnt
`endif
);

  localparam int unsigned LW = $clog2(MAX_BEATS);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_e                               state;
  logic [LW-1:0]                        len_q;
  logic [LW-1:0]                        beat;
  logic [LW-1:0]                        beat_nx;
  logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] wbuf;
  logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] rbuf;
  logic                                 to_clr;
  logic                                 to_en;
  logic                                 to_expired;

  assign beat_nx   = beat + LW'(1);
  assign rsp_rdata = rbuf;
  assign wbm_bte_o = BTE_LINEAR;

  // Timer runs only while on the bus; each ack restarts the window.
  assign to_en  = (state == BUS);
  assign to_clr = (state != BUS) || wbm_ack_i;

  wb_fuzz_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  // Control FSM: accept request, run burst, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_beats  <= '0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= '1;
      wbm_cti_o  <= CTI_CLASSIC;
      len_q      <= '0;
      beat       <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wbuf       <= req_wdata;
            rbuf       <= '0;
            len_q      <= req_len;
            beat       <= '0;
            rsp_beats  <= '0;
            rsp_status <= ST_OK;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_we_o   <= req_we;
            wbm_adr_o  <= req_addr;
            wbm_sel_o  <= req_sel;
            wbm_dat_o  <= req_wdata[DATA_WIDTH-1:0];
            // single-beat requests go out as classic cycles
            wbm_cti_o  <= (req_len == '0) ? CTI_CLASSIC : CTI_INCR;
            req_ready  <= 1'b0;
            state      <= BUS;
          end
        end
        BUS: begin
          // err takes priority over a simultaneous ack; that beat is not counted
          if (wbm_err_i) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cti_o  <= CTI_CLASSIC;
            rsp_status <= ST_ERR;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (wbm_ack_i) begin
            if (!wbm_we_o) rbuf[beat] <= wbm_dat_i;
            rsp_beats <= rsp_beats + (LW+1)'(1);
            if (beat == len_q) begin
              wbm_cyc_o  <= 1'b0;
              wbm_stb_o  <= 1'b0;
              wbm_cti_o  <= CTI_CLASSIC;
              rsp_status <= ST_OK;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              beat      <= beat_nx;
              wbm_adr_o <= wbm_adr_o + STEP;
              wbm_dat_o <= wbuf[beat_nx];
              wbm_cti_o <= (beat_nx == len_q) ? CTI_END : CTI_INCR;
            end
          end else if (to_expired) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cti_o  <= CTI_CLASSIC;
            rsp_status <= ST_TIMEOUT;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FUZZ_STATS_EN
  // Saturating counts of delivered responses, split out by failure kind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_txn_cnt <= '0;
      stat_err_cnt <= '0;
      stat_to_cnt  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (stat_txn_cnt != '1) stat_txn_cnt <= stat_txn_cnt + 32'd1;
      if (rsp_status == ST_ERR && stat_err_cnt != '1)
        stat_err_cnt <= stat_err_cnt + 16'd1;
      if (rsp_status == ST_TIMEOUT && stat_to_cnt != '1)
        stat_to_cnt <= stat_to_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_fuzz_burst_master.sv
// Scoreboard bench for wb_fuzz_burst_master: expected bus beats and
// responses are queued when a request is driven and checked as the DUT
// produces them.
`timescale 1ns/1ps
module tb_wb_fuzz_burst_master;
  import wb_fuzz_pkg::*;

  localparam int AW = 32, DW = 32, MB = 8, TO = 16, LW = 3, SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [LW-1:0]     req_len = '0;
  logic [SW-1:0]     req_sel = '0;
  logic [MB*DW-1:0]  req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [MB*DW-1:0]  rsp_rdata;
  logic [1:0]        rsp_status;
  logic [LW:0]       rsp_beats;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o, wbm_dat_i;
  logic [SW-1:0]     wbm_sel_o;
  logic [2:0]        wbm_cti_o;
  logic [1:0]        wbm_bte_o;
  logic              wbm_ack_i, wbm_err_i;

  wb_fuzz_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_sel(req_sel),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_beats(rsp_beats),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_o(wbm_sel_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  // slave model: zero-wait acks, data = base + beat index, optional err/stall
  int            sl_beat;
  int            sl_err_beat = -1;
  int            sl_stall_beat = -1;
  logic          sl_ack_en = 1'b1;
  logic [DW-1:0] sl_base = '0;

  always_comb begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    if (wbm_cyc_o && wbm_stb_o) begin
      wbm_dat_i = sl_base + DW'(sl_beat);
      wbm_ack_i = sl_ack_en && (sl_beat != sl_stall_beat);
      wbm_err_i = (sl_beat == sl_err_beat);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        sl_beat <= 0;
    else if (!wbm_cyc_o)               sl_beat <= 0;
    else if (wbm_ack_i && !wbm_err_i)  sl_beat <= sl_beat + 1;
  end

  typedef struct {
    logic [AW-1:0] adr;
    logic [2:0]    cti;
    logic [SW-1:0] sel;
    logic          we;
    logic [DW-1:0] dat;
  } bus_t;

  typedef struct {
    logic [1:0]       st;
    logic [LW:0]      beats;
    logic [MB*DW-1:0] rdata;
  } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  bus_t mb;

  function automatic void push_bus(input logic [AW-1:0] a, input logic [2:0] c,
                                   input logic [SW-1:0] s, input logic w, input logic [DW-1:0] d);
    bus_t b;
    b.adr = a; b.cti = c; b.sel = s; b.we = w; b.dat = d;
    exp_bus.push_back(b);
  endfunction

  function automatic void push_rsp(input logic [1:0] st, input int beats, input logic [MB*DW-1:0] rd);
    rsp_t r;
    r.st = st; r.beats = (LW+1)'(beats); r.rdata = rd;
    exp_rsp.push_back(r);
  endfunction

  // bus monitor: every acked beat is checked against the next expected beat
  always @(negedge clk) begin
    if (rst_n && wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i) begin
      chk("bus_beat_expected", exp_bus.size() > 0, 1'b1);
      if (exp_bus.size() > 0) begin
        mb = exp_bus.pop_front();
        chk("adr", wbm_adr_o, mb.adr);
        chk("cti", wbm_cti_o, mb.cti);
        chk("sel", wbm_sel_o, mb.sel);
        chk("we", wbm_we_o, mb.we);
        chk("bte", wbm_bte_o, BTE_LINEAR);
        if (mb.we) chk("dat_o", wbm_dat_o, mb.dat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input int len,
                       input logic [SW-1:0] s, input logic [MB*DW-1:0] wd);
    wait_ready();
    req_we = w; req_addr = a; req_len = LW'(len); req_sel = s; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // issue one request, check latency, cyc duration, response and hold behaviour
  task automatic send(input logic w, input logic [AW-1:0] a, input int len,
                      input logic [SW-1:0] s, input logic [MB*DW-1:0] wd,
                      input int hold, input int exp_lat, input int exp_cyc);
    int lat = 0;
    int ncyc = 0;
    rsp_t r;
    logic [MB*DW-1:0] cap_rd;
    logic [1:0] cap_st;
    logic [LW:0] cap_bt;
    rsp_ready = (hold == 0);
    drive(w, a, len, s, wd);
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (wbm_cyc_o) ncyc++;
    end
    chk("rsp_latency", lat, exp_lat);
    chk("cyc_cycles", ncyc, exp_cyc);
    chk("cyc_low_at_rsp", wbm_cyc_o, 1'b0);
    chk("rsp_expected", exp_rsp.size() > 0, 1'b1);
    if (exp_rsp.size() > 0) begin
      r = exp_rsp.pop_front();
      chk("rsp_status", rsp_status, r.st);
      chk("rsp_beats", rsp_beats, r.beats);
      chk("rsp_rdata", rsp_rdata, r.rdata);
    end
    cap_rd = rsp_rdata; cap_st = rsp_status; cap_bt = rsp_beats;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, cap_rd);
      chk("hold_status", rsp_status, cap_st);
      chk("hold_beats", rsp_beats, cap_bt);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("ready_after_rsp", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [MB*DW-1:0] rd;
    logic [MB*DW-1:0] wd;
    int n;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_sel", wbm_sel_o, 4'hF);
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cti", wbm_cti_o, 3'b000);
    rst_n = 1'b1;

    // full 8-beat read, zero-wait slave
    sl_base = 32'hA0;
    rd = '0;
    for (int i = 0; i < 8; i++) begin
      push_bus(32'h1000 + 32'(4 * i), (i < 7) ? CTI_INCR : CTI_END, 4'hF, 1'b0, '0);
      rd[i*DW +: DW] = 32'hA0 + 32'(i);
    end
    push_rsp(ST_OK, 8, rd);
    send(1'b0, 32'h1000, 7, 4'hF, '0, 0, 9, 8);

    // single classic write with partial byte select
    wd = '0;
    wd[DW-1:0] = 32'hDEADBEEF;
    push_bus(32'h20, CTI_CLASSIC, 4'b0011, 1'b1, 32'hDEADBEEF);
    push_rsp(ST_OK, 1, '0);
    send(1'b1, 32'h20, 0, 4'b0011, wd, 0, 2, 1);

    // read burst aborted by err on beat 2 (ack also high: err must win)
    sl_base = 32'h50;
    sl_err_beat = 2;
    rd = '0;
    for (int i = 0; i < 2; i++) begin
      push_bus(32'h200 + 32'(4 * i), CTI_INCR, 4'hF, 1'b0, '0);
      rd[i*DW +: DW] = 32'h50 + 32'(i);
    end
    push_rsp(ST_ERR, 2, rd);
    send(1'b0, 32'h200, 3, 4'hF, '0, 0, 4, 3);
    sl_err_beat = -1;

    // unresponsive slave
    sl_ack_en = 1'b0;
    push_rsp(ST_TIMEOUT, 0, '0);
    send(1'b0, 32'h300, 2, 4'hF, '0, 0, TO + 1, TO);
    sl_ack_en = 1'b1;

    // write burst wrapping the address space, response held 5 cycles
    wd = '0;
    wd[0*DW +: DW] = 32'h11111111;
    wd[1*DW +: DW] = 32'h22222222;
    push_bus(32'hFFFF_FFFC, CTI_INCR, 4'hF, 1'b1, 32'h11111111);
    push_bus(32'h0000_0000, CTI_END, 4'hF, 1'b1, 32'h22222222);
    push_rsp(ST_OK, 2, '0);
    send(1'b1, 32'hFFFF_FFFC, 1, 4'hF, wd, 5, 3, 2);

    // reset asserted while the slave stalls beat 3
    sl_base = 32'h70;
    sl_stall_beat = 3;
    for (int i = 0; i < 3; i++)
      push_bus(32'h400 + 32'(4 * i), CTI_INCR, 4'hF, 1'b0, '0);
    drive(1'b0, 32'h400, 7, 4'hF, '0);
    n = 0;
    while (sl_beat != 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_beat_reached", sl_beat, 3);
    chk("cyc_before_rst", wbm_cyc_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_cyc", wbm_cyc_o, 1'b0);
    chk("async_stb", wbm_stb_o, 1'b0);
    chk("async_rsp_valid", rsp_valid, 1'b0);
    chk("async_req_ready", req_ready, 1'b1);
    chk("async_rdata", rsp_rdata, '0);
    chk("bus_q_after_rst", exp_bus.size(), 0);
    @(negedge clk);
    chk("no_rsp_in_rst", rsp_valid, 1'b0);
    rst_n = 1'b1;
    sl_stall_beat = -1;

    // normal request after reset
    sl_base = 32'h10;
    push_bus(32'h40, CTI_INCR, 4'hF, 1'b0, '0);
    push_bus(32'h44, CTI_END, 4'hF, 1'b0, '0);
    rd = '0;
    rd[0*DW +: DW] = 32'h10;
    rd[1*DW +: DW] = 32'h11;
    push_rsp(ST_OK, 2, rd);
    send(1'b0, 32'h40, 1, 4'hF, '0, 0, 3, 2);

    chk("bus_q_drained", exp_bus.size(), 0);
    chk("rsp_q_drained", exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
